// File: rtl/sobel_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sobel_pkg
// Description : Raster constants and shared types for the Sobel pixel path.
// Revision    : 1.0 - initial release
// ============================================================================
package sobel_pkg;

    localparam int H_ACT   = 640;
    localparam int H_FP    = 16;
    localparam int H_SYNC  = 96;
    localparam int H_BP    = 48;
    localparam int H_TOTAL = H_ACT + H_FP + H_SYNC + H_BP;

    localparam int V_ACT   = 480;
    localparam int V_FP    = 10;
    localparam int V_SYNC  = 2;
    localparam int V_BP    = 29;
    localparam int V_TOTAL = V_ACT + V_FP + V_SYNC + V_BP;

    localparam int ADDR_W  = 19;
    localparam int PIX_W   = 8;
    localparam int FCNT_W  = 16;

    // Per-cycle raster flags carried through the read-latency alignment pipe
    typedef struct packed {
        logic active;
        logic hs;
        logic vs;
        logic sof;
        logic eol;
        logic boundary;
    } raster_flags_t;

endpackage
`default_nettype wire

// File: rtl/frame_stream_source_if.sv
`default_nettype none
// ============================================================================
// Module      : frame_stream_source_if
// Description : Frame-memory read port plus outgoing pixel stream.
// Revision    : 1.0 - initial release
// ============================================================================
interface frame_stream_source_if;
    import sobel_pkg::*;

    logic                mem_rd;
    logic [ADDR_W-1:0]   mem_addr;
    logic [PIX_W-1:0]    mem_data;
    logic [PIX_W-1:0]    pix_data;
    logic                pix_valid;
    logic                hs;
    logic                vs;
    logic                sof;
    logic                eol;
    logic                frame_done;
    logic [FCNT_W-1:0]   frame_cnt;

    modport master (
        output mem_rd, mem_addr, pix_data, pix_valid, hs, vs,
               sof, eol, frame_done, frame_cnt,
        input  mem_data
    );

    modport slave (
        input  mem_rd, mem_addr, pix_data, pix_valid, hs, vs,
               sof, eol, frame_done, frame_cnt,
        output mem_data
    );

endinterface
`default_nettype wire

// File: rtl/frame_stream_source_raster_counter.sv
`default_nettype none
// ============================================================================
// Module      : raster_counter
// Description : h/v raster counters with raw active/sync/marker decode.
// Revision    : 1.0 - initial release
// ============================================================================
module raster_counter #(
    parameter int H_ACT  = sobel_pkg::H_ACT,
    parameter int H_FP   = sobel_pkg::H_FP,
    parameter int H_SYNC = sobel_pkg::H_SYNC,
    parameter int H_BP   = sobel_pkg::H_BP,
    parameter int V_ACT  = sobel_pkg::V_ACT,
    parameter int V_FP   = sobel_pkg::V_FP,
    parameter int V_SYNC = sobel_pkg::V_SYNC,
    parameter int V_BP   = sobel_pkg::V_BP
) (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic i_run,
    output logic      o_active,
    output logic      o_hs,
    output logic      o_vs,
    output logic      o_sof,
    output logic      o_eol,
    output logic      o_last
);
    import sobel_pkg::*;

    localparam int c_h_total = H_ACT + H_FP + H_SYNC + H_BP;
    localparam int c_v_total = V_ACT + V_FP + V_SYNC + V_BP;
    localparam int c_hw      = $clog2(c_h_total);
    localparam int c_vw      = $clog2(c_v_total);

    localparam logic [c_hw-1:0] c_h_act  = c_hw'(H_ACT);
    localparam logic [c_hw-1:0] c_h_eol  = c_hw'(H_ACT - 1);
    localparam logic [c_hw-1:0] c_hs_beg = c_hw'(H_ACT + H_FP);
    localparam logic [c_hw-1:0] c_hs_end = c_hw'(H_ACT + H_FP + H_SYNC);
    localparam logic [c_hw-1:0] c_h_last = c_hw'(c_h_total - 1);
    localparam logic [c_vw-1:0] c_v_act  = c_vw'(V_ACT);
    localparam logic [c_vw-1:0] c_vs_beg = c_vw'(V_ACT + V_FP);
    localparam logic [c_vw-1:0] c_vs_end = c_vw'(V_ACT + V_FP + V_SYNC);
    localparam logic [c_vw-1:0] c_v_last = c_vw'(c_v_total - 1);

    logic [c_hw-1:0] h_cnt_q, h_cnt_d;
    logic [c_vw-1:0] v_cnt_q, v_cnt_d;

    // Counters sit at 0 while not running so a new frame always starts at (0,0)
    always_comb begin
        h_cnt_d = h_cnt_q;
        v_cnt_d = v_cnt_q;
        if (!i_run) begin
            h_cnt_d = '0;
            v_cnt_d = '0;
        end else if (h_cnt_q == c_h_last) begin
            h_cnt_d = '0;
            v_cnt_d = (v_cnt_q == c_v_last) ? '0 : v_cnt_q + 1'b1;
        end else begin
            h_cnt_d = h_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            h_cnt_q <= '0;
            v_cnt_q <= '0;
        end else begin
            h_cnt_q <= h_cnt_d;
            v_cnt_q <= v_cnt_d;
        end
    end

    assign o_active = (h_cnt_q < c_h_act) && (v_cnt_q < c_v_act);
    assign o_hs     = (h_cnt_q >= c_hs_beg) && (h_cnt_q < c_hs_end);
    assign o_vs     = (v_cnt_q >= c_vs_beg) && (v_cnt_q < c_vs_end);
    assign o_sof    = (h_cnt_q == '0) && (v_cnt_q == '0);
    assign o_eol    = (h_cnt_q == c_h_eol) && (v_cnt_q < c_v_act);
    assign o_last   = (h_cnt_q == c_h_last) && (v_cnt_q == c_v_last);

endmodule
`default_nettype wire

// File: rtl/frame_stream_source.sv
`default_nettype none
// ============================================================================
// Module      : frame_stream_source
// Description : Streams a stored greyscale frame into the Sobel pipeline raster.
// Revision    : 1.0 - initial release
// ============================================================================
module frame_stream_source #(
    parameter int   H_ACT    = sobel_pkg::H_ACT,
    parameter int   H_FP     = sobel_pkg::H_FP,
    parameter int   H_SYNC   = sobel_pkg::H_SYNC,
    parameter int   H_BP     = sobel_pkg::H_BP,
    parameter int   V_ACT    = sobel_pkg::V_ACT,
    parameter int   V_FP     = sobel_pkg::V_FP,
    parameter int   V_SYNC   = sobel_pkg::V_SYNC,
    parameter int   V_BP     = sobel_pkg::V_BP,
    parameter int   RD_LAT   = 1,
    parameter logic SYNC_POL = 1'b0
) (
    input  wire logic              clk,
    input  wire logic              rst,
    input  wire logic              en,
    frame_stream_source_if.master  fss
);
    import sobel_pkg::*;

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    localparam logic [ADDR_W-1:0] c_last_addr = ADDR_W'(H_ACT * V_ACT - 1);

    logic [0:0]          state_q, state_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [FCNT_W-1:0]   frame_cnt_q, frame_cnt_d;
    raster_flags_t       stage_q [RD_LAT];
    raster_flags_t       stage_d [RD_LAT];

    logic                w_run;
    logic                w_active, w_hs, w_vs, w_sof, w_eol, w_last;
    raster_flags_t       w_raw;
    raster_flags_t       w_out;

    assign w_run = (state_q == S_RUN);

    raster_counter #(
        .H_ACT (H_ACT),  .H_FP (H_FP),  .H_SYNC (H_SYNC),  .H_BP (H_BP),
        .V_ACT (V_ACT),  .V_FP (V_FP),  .V_SYNC (V_SYNC),  .V_BP (V_BP)
    ) u_raster (
        .clk      (clk),
        .rst      (rst),
        .i_run    (w_run),
        .o_active (w_active),
        .o_hs     (w_hs),
        .o_vs     (w_vs),
        .o_sof    (w_sof),
        .o_eol    (w_eol),
        .o_last   (w_last)
    );

    // en only matters when leaving IDLE or at the last raster cycle of a frame
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (en) state_d = S_RUN;
            S_RUN:   if (w_last && !en) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Address wraps after the final active pixel so it never leaves the frame
    always_comb begin
        mem_addr_d = mem_addr_q;
        if (w_run && w_active)
            mem_addr_d = (mem_addr_q == c_last_addr) ? '0 : mem_addr_q + 1'b1;
        if (w_run && w_last)
            mem_addr_d = '0;
    end

    always_comb begin
        w_raw = '{active: w_active, hs: w_hs, vs: w_vs,
                  sof: w_sof, eol: w_eol, boundary: w_last};
        stage_d[0] = w_run ? w_raw : '0;
        for (int i = 1; i < RD_LAT; i++)
            stage_d[i] = stage_q[i-1];
        // Count lands on the same edge frame_done appears at the output
        frame_cnt_d = frame_cnt_q + FCNT_W'(stage_d[RD_LAT-1].boundary);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            mem_addr_q  <= '0;
            frame_cnt_q <= '0;
            for (int i = 0; i < RD_LAT; i++)
                stage_q[i] <= '0;
        end else begin
            state_q     <= state_d;
            mem_addr_q  <= mem_addr_d;
            frame_cnt_q <= frame_cnt_d;
            for (int i = 0; i < RD_LAT; i++)
                stage_q[i] <= stage_d[i];
        end
    end

    assign w_out = stage_q[RD_LAT-1];

    assign fss.mem_rd     = w_run && w_active;
    assign fss.mem_addr   = mem_addr_q;
    assign fss.pix_valid  = w_out.active;
    assign fss.pix_data   = w_out.active ? fss.mem_data : '0;
    assign fss.hs         = w_out.hs ? SYNC_POL : ~SYNC_POL;
    assign fss.vs         = w_out.vs ? SYNC_POL : ~SYNC_POL;
    assign fss.sof        = w_out.sof;
    assign fss.eol        = w_out.eol;
    assign fss.frame_done = w_out.boundary;
    assign fss.frame_cnt  = frame_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_frame_stream_source.sv
`default_nettype none
// ============================================================================
// Module      : tb_frame_stream_source
// Description : Scoreboard bench for frame_stream_source on a reduced raster.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_frame_stream_source;

    localparam int TH_ACT  = 16;
    localparam int TH_FP   = 2;
    localparam int TH_SYNC = 4;
    localparam int TH_BP   = 3;
    localparam int TV_ACT  = 6;
    localparam int TV_FP   = 1;
    localparam int TV_SYNC = 2;
    localparam int TV_BP   = 1;
    localparam int TH_TOT  = TH_ACT + TH_FP + TH_SYNC + TH_BP;
    localparam int TV_TOT  = TV_ACT + TV_FP + TV_SYNC + TV_BP;
    localparam int FRAME   = TH_TOT * TV_TOT;

    logic clk = 1'b0;
    logic rst;
    logic en;
    logic [7:0] mem_key;
    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    typedef struct {
        bit rd;
        bit chk_addr;
        int addr;
    } mem_exp_t;

    typedef struct {
        bit         valid;
        logic [7:0] data;
        bit         hs;
        bit         vs;
        bit         sof;
        bit         eol;
        bit         done;
        int         fcnt;
    } pix_exp_t;

    function automatic logic [7:0] mem_word(input int addr);
        return 8'(addr) ^ mem_key;
    endfunction

    task automatic check(input int inst, input string name,
                         input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL dut%0d %s: got 0x%0h expected 0x%0h at %0t",
                     inst, name, act, exp, $time);
        end
    endtask

    for (genvar gi = 0; gi < 2; gi++) begin : g_dut
        localparam int   LAT = (gi == 0) ? 1 : 3;
        localparam logic POL = (gi == 0) ? 1'b0 : 1'b1;

        frame_stream_source_if fss();

        frame_stream_source #(
            .H_ACT (TH_ACT), .H_FP (TH_FP), .H_SYNC (TH_SYNC), .H_BP (TH_BP),
            .V_ACT (TV_ACT), .V_FP (TV_FP), .V_SYNC (TV_SYNC), .V_BP (TV_BP),
            .RD_LAT (LAT), .SYNC_POL (POL)
        ) u_dut (
            .clk (clk),
            .rst (rst),
            .en  (en),
            .fss (fss)
        );

        // Frame memory: garbage on idle cycles so ungated pix_data shows up
        logic [7:0] rd_pipe [LAT];
        always @(posedge clk) begin
            rd_pipe[0] <= fss.mem_rd ? mem_word(int'(fss.mem_addr)) : 8'($urandom);
            for (int i = 1; i < LAT; i++)
                rd_pipe[i] <= rd_pipe[i-1];
        end
        assign fss.mem_data = rd_pipe[LAT-1];

        mem_exp_t qm[$];
        pix_exp_t qp[$];
        bit running;
        int x, y, fcnt;

        function automatic pix_exp_t idle_pix(input int c);
            pix_exp_t p;
            p.valid = 0; p.data = 8'h00; p.hs = ~POL; p.vs = ~POL;
            p.sof = 0; p.eol = 0; p.done = 0; p.fcnt = c;
            return p;
        endfunction

        // Reference: raster position after each edge -> expected stream entry
        initial begin
            running = 0; x = 0; y = 0; fcnt = 0;
            forever begin
                @(posedge clk);
                if (rst) begin
                    running = 0; x = 0; y = 0; fcnt = 0;
                    qm.delete();
                    qp.delete();
                    repeat (LAT) qp.push_back(idle_pix(0));
                end else if (!running) begin
                    if (en) begin
                        running = 1; x = 0; y = 0;
                    end
                end else if (x == TH_TOT - 1) begin
                    x = 0;
                    if (y == TV_TOT - 1) begin
                        y = 0;
                        running = en;
                    end else begin
                        y++;
                    end
                end else begin
                    x++;
                end

                if (running) begin
                    mem_exp_t m;
                    pix_exp_t p;
                    bit act;
                    act = (x < TH_ACT) && (y < TV_ACT);
                    m.rd = act; m.chk_addr = act; m.addr = y * TH_ACT + x;
                    p.valid = act;
                    p.data  = act ? mem_word(y * TH_ACT + x) : 8'h00;
                    p.hs    = (x >= TH_ACT + TH_FP && x < TH_ACT + TH_FP + TH_SYNC) ? POL : ~POL;
                    p.vs    = (y >= TV_ACT + TV_FP && y < TV_ACT + TV_FP + TV_SYNC) ? POL : ~POL;
                    p.sof   = (x == 0) && (y == 0);
                    p.eol   = (x == TH_ACT - 1) && (y < TV_ACT);
                    p.done  = (x == TH_TOT - 1) && (y == TV_TOT - 1);
                    if (p.done) fcnt++;
                    p.fcnt  = fcnt;
                    qm.push_back(m);
                    qp.push_back(p);
                end else begin
                    mem_exp_t m;
                    m.rd = 0; m.chk_addr = 1; m.addr = 0;
                    qm.push_back(m);
                    qp.push_back(idle_pix(fcnt));
                end
            end
        end

        // Monitor: pops one expected entry per cycle, compares away from the edge
        initial begin
            int vcnt;
            mem_exp_t m;
            pix_exp_t p;
            vcnt = 0;
            forever begin
                @(negedge clk);
                check(gi, "sb_depth", 32'(qp.size()), 32'(LAT + 1));
                if (qp.size() > 0 && qm.size() > 0) begin
                    m = qm.pop_front();
                    p = qp.pop_front();
                    check(gi, "mem_rd", 32'(fss.mem_rd), 32'(m.rd));
                    if (m.chk_addr)
                        check(gi, "mem_addr", 32'(fss.mem_addr), 32'(m.addr));
                    check(gi, "pix_valid",  32'(fss.pix_valid),  32'(p.valid));
                    check(gi, "pix_data",   32'(fss.pix_data),   32'(p.data));
                    check(gi, "hs",         32'(fss.hs),         32'(p.hs));
                    check(gi, "vs",         32'(fss.vs),         32'(p.vs));
                    check(gi, "sof",        32'(fss.sof),        32'(p.sof));
                    check(gi, "eol",        32'(fss.eol),        32'(p.eol));
                    check(gi, "frame_done", 32'(fss.frame_done), 32'(p.done));
                    check(gi, "frame_cnt",  32'(fss.frame_cnt),  32'(p.fcnt & 16'hFFFF));
                    if (p.sof) vcnt = 0;
                    if (fss.pix_valid) vcnt++;
                    if (p.done) begin
                        check(gi, "valid_per_frame", 32'(vcnt), 32'(TH_ACT * TV_ACT));
                        vcnt = 0;
                    end
                end
            end
        end
    end

    initial begin
        mem_key = 8'($urandom);
        rst = 1'b1;
        en  = 1'b1;
        repeat (5) @(negedge clk);
        rst = 1'b0;

        // Two back-to-back frames, then reset a few lines into the third
        repeat (2 * FRAME + 3 * TH_TOT + 7) @(negedge clk);
        rst = 1'b1;
        en  = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        // en dropped mid-frame: the frame must still complete, then idle
        en = 1'b1;
        repeat (3 * TH_TOT) @(negedge clk);
        en = 1'b0;
        repeat (FRAME + 20) @(negedge clk);

        for (int k = 0; k < 40; k++) begin
            en = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 11) == 0) begin
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
            end
            repeat ($urandom_range(1, 300)) @(negedge clk);
        end

        en = 1'b0;
        repeat (FRAME + 10) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
